tetris_input_arbiter: RTL and testbench

Conditions the six raw game buttons (move left/right, rotate left/right, fast move, reset game) and turns them into a single ordered stream of one-shot game events for the Nios CPU. It sits between the board pins and the input PIOs of the `tetris_nios` system. It sequences debouncing, auto-repeat and round-robin arbitration into a small event FIFO, so the CPU never misses or double-counts a press.

---
 rtl/tetris_input_arbiter_pkg.sv | 36 +++
 rtl/tetris_input_arbiter_if.sv | 15 +
 rtl/tetris_input_arbiter_debouncer.sv | 51 +++++
 rtl/tetris_input_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_tetris_input_arbiter.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/tetris_input_arbiter_pkg.sv
// tetris_input_pkg: shared types and constants for the Tetris input arbiter.
//   evt_code_e   - event codes delivered to the CPU (0 means "no event")
//   BTN_*        - bit positions of the raw buttons on btn_n
//   rpt_state_e  - states of the per-button auto-repeat FSM
//   btn_to_evt() - maps a granted source index (0..3) to its event code
package tetris_input_pkg;

  typedef enum logic [2:0] {
    EVT_NONE       = 3'd0,
    EVT_LEFT       = 3'd1,
    EVT_RIGHT      = 3'd2,
    EVT_ROT_LEFT   = 3'd3,
    EVT_ROT_RIGHT  = 3'd4,
    EVT_RESET_GAME = 3'd5
  } evt_code_e;

  localparam int NUM_BTN        = 6;
  localparam int BTN_MOVE_LEFT  = 0;
  localparam int BTN_MOVE_RIGHT = 1;
  localparam int BTN_ROT_LEFT   = 2;
  localparam int BTN_ROT_RIGHT  = 3;
  localparam int BTN_FAST_MOVE  = 4;
  localparam int BTN_RESET_GAME = 5;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  // Sources 0..3 map directly onto codes 1..4.
  function automatic evt_code_e btn_to_evt(input logic [1:0] idx);
    return evt_code_e'({1'b0, idx} + 3'd1);
  endfunction

endpackage

// File: rtl/tetris_input_arbiter_if.sv
// tetris_input_arbiter_if: event stream handshake between the arbiter and the CPU.
//   evt_valid - FIFO holds at least one event
//   evt_code  - head event (EVT_NONE when empty)
//   evt_ready - pop strobe; an entry is consumed when evt_valid & evt_ready
// master = event producer (arbiter), slave = event consumer.
interface tetris_input_arbiter_if;
  import tetris_input_pkg::*;

  logic      evt_valid;
  evt_code_e evt_code;
  logic      evt_ready;

  modport master (output evt_valid, output evt_code, input evt_ready);
  modport slave  (input evt_valid, input evt_code, output evt_ready);
endinterface

// File: rtl/tetris_input_arbiter_debouncer.sv
// input_debouncer: 2-FF synchronizer plus counting debouncer for one button.
//   clk   - system clock
//   srst  - synchronous active-high reset (state returns to "released")
//   btn_n - raw active-low asynchronous button
//   level - debounced active-high level
// The counter runs while the synchronized value disagrees with the debounced
// state and clears on any agreeing cycle; the state flips on the cycle after
// the count has reached DEBOUNCE_CYCLES.
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic srst,
  input  logic btn_n,
  output logic level
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    if (sync2_q != state_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
        state_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // Inverting at the input keeps the reset value 0 meaning "released".
      sync1_q <= ~btn_n;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = state_q;
endmodule

// File: rtl/tetris_input_arbiter.sv
// tetris_input_arbiter: turns six raw buttons into an ordered stream of
// one-shot game events (debounce -> auto-repeat -> round-robin -> FIFO).
//   clk_clk         - system clock
//   reset_reset     - synchronous active-high reset
//   btn_n[5:0]      - raw active-low buttons (see BTN_* in the package)
//   evt_if          - event stream (valid / code / ready), master side
//   fast_move_level - debounced fast_move level
//   overflow        - sticky flag: a request was coalesced and lost
//   overflow_clr    - clears overflow (a same-cycle new overflow wins)
module tetris_input_arbiter
  import tetris_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 15000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                        clk_clk,
  input  logic                        reset_reset,
  input  logic [NUM_BTN-1:0]          btn_n,
  tetris_input_arbiter_if.master      evt_if,
  output logic                        fast_move_level,
  output logic                        overflow,
  input  logic                        overflow_clr
);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  // Sources that produce events on a debounced rising edge.
  localparam logic [NUM_BTN-1:0] EVT_SRC_MASK = NUM_BTN'((1 << BTN_MOVE_LEFT) |
      (1 << BTN_MOVE_RIGHT) | (1 << BTN_ROT_LEFT) | (1 << BTN_ROT_RIGHT) | (1 << BTN_RESET_GAME));

  logic [NUM_BTN-1:0] db_level, db_prev_q, rise, set_req;
  logic [NUM_BTN-1:0] pending_q, pending_d, clear_mask, dropped;
  logic [1:0]         rpt_fire;
  logic [1:0]         rr_ptr_q, rr_ptr_d, grant_idx, cand;
  logic               grant_found, flush, push, pop, empty, full;
  logic               overflow_q, overflow_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, wr_addr;
  logic [PW:0]        count_q, count_d;
  logic               wr_en;
  evt_code_e          wr_data;
  evt_code_e          mem_q [FIFO_DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_db
      input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk   (clk_clk),
        .srst  (reset_reset),
        .btn_n (btn_n[gi]),
        .level (db_level[gi])
      );
    end
  endgenerate

  assign rise = db_level & ~db_prev_q;

  // Auto-repeat for the two move buttons. A debounced release forces IDLE
  // before any timer expiry is considered, so no event follows a release.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rpt
      rpt_state_e    rpt_q, rpt_d;
      logic [RW-1:0] tmr_q, tmr_d;
      logic          fire;

      always_comb begin
        rpt_d = rpt_q;
        tmr_d = tmr_q + RW'(1);
        fire  = 1'b0;
        if (!db_level[BTN_MOVE_LEFT + gi]) begin
          rpt_d = RPT_IDLE;
          tmr_d = '0;
        end else begin
          case (rpt_q)
            RPT_IDLE: begin
              tmr_d = '0;
              if (rise[BTN_MOVE_LEFT + gi]) rpt_d = RPT_DELAY;
            end
            RPT_DELAY: if (tmr_q == RW'(REPEAT_DELAY - 1)) begin
              fire  = 1'b1;
              rpt_d = RPT_REPEAT;
              tmr_d = '0;
            end
            RPT_REPEAT: if (tmr_q == RW'(REPEAT_PERIOD - 1)) begin
              fire  = 1'b1;
              tmr_d = '0;
            end
            default: begin
              rpt_d = RPT_IDLE;
              tmr_d = '0;
            end
          endcase
        end
      end

      always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
          rpt_q <= RPT_IDLE;
          tmr_q <= '0;
        end else begin
          rpt_q <= rpt_d;
          tmr_q <= tmr_d;
        end
      end

      assign rpt_fire[gi] = fire;
    end
  endgenerate

  assign set_req = (rise & EVT_SRC_MASK) | {{(NUM_BTN-2){1'b0}}, rpt_fire};

  // Round-robin search over sources 0..3 starting at rr_ptr_q.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = rr_ptr_q;
    cand        = rr_ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = rr_ptr_q + 2'(k);
      if (!grant_found && pending_q[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == (PW+1)'(FIFO_DEPTH));
  assign pop   = ~empty & evt_if.evt_ready;
  assign flush = pending_q[BTN_RESET_GAME];
  // A same-cycle pop frees the slot, so a full FIFO can still accept a push.
  assign push  = ~flush & grant_found & (~full | pop);

  always_comb begin
    clear_mask = '0;
    if (flush)     clear_mask = '1;
    else if (push) clear_mask = NUM_BTN'(1) << grant_idx;
    // A request for a source whose bit is being granted this cycle is not lost.
    dropped    = set_req & pending_q & ~clear_mask;
    pending_d  = (pending_q & ~clear_mask) | set_req;
    overflow_d = overflow_q;
    if (|dropped)          overflow_d = 1'b1;
    else if (overflow_clr) overflow_d = 1'b0;
    rr_ptr_d = push ? grant_idx + 2'd1 : rr_ptr_q;

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = PW'(1);
      count_d  = (PW+1)'(1);
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    end

    wr_en   = flush | push;
    wr_addr = flush ? '0 : wr_ptr_q;
    wr_data = flush ? EVT_RESET_GAME : btn_to_evt(grant_idx);
  end

  // Storage carries no reset; contents are meaningless while count_q is 0.
  always_ff @(posedge clk_clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      db_prev_q  <= '0;
      pending_q  <= '0;
      rr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      db_prev_q  <= db_level;
      pending_q  <= pending_d;
      rr_ptr_q   <= rr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign evt_if.evt_valid = ~empty;
  assign evt_if.evt_code  = empty ? EVT_NONE : mem_q[rd_ptr_q];
  assign fast_move_level  = db_level[BTN_FAST_MOVE];
  assign overflow         = overflow_q;
endmodule

// File: tb/tb_tetris_input_arbiter.sv
// Self-checking bench for tetris_input_arbiter (small timing parameters).
module tb_tetris_input_arbiter;
  localparam int DC = 4;
  localparam int RD = 20;
  localparam int RP = 8;
  localparam int FD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] btn_n = 6'h3F;
  logic       fast_lvl, ovf;
  logic       ovf_clr = 1'b0;

  tetris_input_arbiter_if evt_if();

  tetris_input_arbiter #(
    .DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .FIFO_DEPTH(FD)
  ) dut (
    .clk_clk         (clk),
    .reset_reset     (rst),
    .btn_n           (btn_n),
    .evt_if          (evt_if),
    .fast_move_level (fast_lvl),
    .overflow        (ovf),
    .overflow_clr    (ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int btn;
    int exp_valid;
    int exp_code;
    int exp_fast;
  } vec_t;

  vec_t tbl [6];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   got_code [$];
  int   got_time [$];
  int   exp_q [$];
  int   gaps [6];

  always @(posedge clk) cyc <= cyc + 1;

  // Records every handshake; inputs are stable by the falling edge.
  always @(negedge clk) begin
    if (evt_if.evt_valid && evt_if.evt_ready) begin
      got_code.push_back(int'(evt_if.evt_code));
      got_time.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_queue(input string name, input int exp[$]);
    check({name, "_count"}, got_code.size(), exp.size());
    for (int k = 0; k < exp.size() && k < got_code.size(); k++)
      check($sformatf("%s_%0d", name, k), got_code[k], exp[k]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    got_code.delete();
    got_time.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, h, n, code;
    evt_if.evt_ready = 1'b0;
    tbl[0] = '{0, 1, 1, 0};
    tbl[1] = '{1, 1, 2, 0};
    tbl[2] = '{2, 1, 3, 0};
    tbl[3] = '{3, 1, 4, 0};
    tbl[4] = '{4, 0, 0, 1};
    tbl[5] = '{5, 1, 5, 0};
    gaps   = '{0, 20, 28, 36, 44, 52};

    // Reset state
    tick(3);
    check("rst_valid", evt_if.evt_valid, 0);
    check("rst_code", int'(evt_if.evt_code), 0);
    check("rst_fast", fast_lvl, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;

    // Single clean press per button: latency, code, fast level, pop
    for (int i = 0; i < 6; i++) begin
      btn_n[tbl[i].btn] = 1'b0;
      tick(6); check($sformatf("tbl%0d_fast_early", i), fast_lvl, 0);
      tick(1); check($sformatf("tbl%0d_fast", i), fast_lvl, tbl[i].exp_fast);
      tick(1); check($sformatf("tbl%0d_valid_early", i), evt_if.evt_valid, 0);
      tick(1);
      check($sformatf("tbl%0d_valid", i), evt_if.evt_valid, tbl[i].exp_valid);
      check($sformatf("tbl%0d_code", i), int'(evt_if.evt_code), tbl[i].exp_code);
      btn_n = 6'h3F;
      if (tbl[i].exp_valid != 0) begin
        evt_if.evt_ready = 1'b1;
        tick(1);
        evt_if.evt_ready = 1'b0;
        check($sformatf("tbl%0d_pop_valid", i), evt_if.evt_valid, 0);
        check($sformatf("tbl%0d_pop_code", i), int'(evt_if.evt_code), 0);
      end
      tick(30);
      check($sformatf("tbl%0d_no_extra", i), evt_if.evt_valid, 0);
    end

    // Bouncing move_right gives exactly one event
    do_reset();
    evt_if.evt_ready = 1'b1;
    for (int p = 0; p < 5; p++) begin
      btn_n[1] = 1'b0; tick(3);
      btn_n[1] = 1'b1; tick(3);
    end
    btn_n[1] = 1'b0; tick(12);
    btn_n[1] = 1'b1; tick(30);
    exp_q = '{2};
    check_queue("bounce", exp_q);

    // Held move_left: first event plus five repeats at fixed offsets
    do_reset();
    evt_if.evt_ready = 1'b1;
    btn_n[0] = 1'b0; tick(56);
    btn_n[0] = 1'b1; tick(40);
    exp_q = '{1, 1, 1, 1, 1, 1};
    check_queue("hold", exp_q);
    if (got_time.size() == 6)
      for (int k = 1; k < 6; k++)
        check($sformatf("hold_gap%0d", k), got_time[k] - got_time[0], gaps[k]);

    // Four simultaneous presses fill the FIFO; pending holds, then overflow
    do_reset();
    evt_if.evt_ready = 1'b0;
    btn_n[3:0] = 4'h0; tick(10);
    btn_n[3:0] = 4'hF; tick(20);
    check("full_valid", evt_if.evt_valid, 1);
    check("full_head", int'(evt_if.evt_code), 1);
    check("full_ovf0", ovf, 0);
    btn_n[3] = 1'b0; tick(10); btn_n[3] = 1'b1; tick(20);
    check("full_pending_ovf", ovf, 0);
    btn_n[3] = 1'b0; tick(10); btn_n[3] = 1'b1; tick(20);
    check("full_ovf_set", ovf, 1);
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
    check("ovf_clr", ovf, 0);
    evt_if.evt_ready = 1'b1; tick(10); evt_if.evt_ready = 1'b0;
    exp_q = '{1, 2, 3, 4, 4};
    check_queue("fifo_order", exp_q);
    check("drained_valid", evt_if.evt_valid, 0);

    // reset_game flushes the FIFO and becomes the only entry
    do_reset();
    btn_n[2:0] = 3'b000; tick(10);
    btn_n[2:0] = 3'b111; tick(20);
    check("preflush_head", int'(evt_if.evt_code), 1);
    btn_n[5] = 1'b0; tick(10); btn_n[5] = 1'b1; tick(20);
    check("flush_valid", evt_if.evt_valid, 1);
    check("flush_head", int'(evt_if.evt_code), 5);
    got_code.delete();
    evt_if.evt_ready = 1'b1; tick(5); evt_if.evt_ready = 1'b0;
    exp_q = '{5};
    check_queue("flush_only", exp_q);

    // Reset while full with a repeat running and fast_move held
    do_reset();
    btn_n[4:0] = 5'b00000; tick(10);
    btn_n[3:1] = 3'b111; tick(40);
    check("prerst_valid", evt_if.evt_valid, 1);
    check("prerst_fast", fast_lvl, 1);
    check("prerst_ovf", ovf, 1);
    rst = 1'b1; tick(1);
    check("midrst_valid", evt_if.evt_valid, 0);
    check("midrst_code", int'(evt_if.evt_code), 0);
    check("midrst_fast", fast_lvl, 0);
    check("midrst_ovf", ovf, 0);
    rst = 1'b0;
    tick(8); check("postrst_valid_early", evt_if.evt_valid, 0);
    tick(1);
    check("postrst_valid", evt_if.evt_valid, 1);
    check("postrst_code", int'(evt_if.evt_code), 1);
    check("postrst_fast", fast_lvl, 1);
    btn_n = 6'h3F;
    evt_if.evt_ready = 1'b1; tick(40); evt_if.evt_ready = 1'b0;

    // Randomized single presses against an arithmetic event-count model
    do_reset();
    exp_q.delete();
    evt_if.evt_ready = 1'b1;
    for (int it = 0; it < 25; it++) begin
      b = $urandom_range(0, 5);
      h = $urandom_range(6, 60);
      btn_n[b] = 1'b0; tick(h);
      btn_n[b] = 1'b1; tick(25);
      // Debounced high for h cycles; repeats need RD + k*RP <= h-1.
      if (b <= 1) begin
        n = 1;
        if (h - 1 >= RD) n = n + 1 + (h - 1 - RD) / RP;
      end else if (b == 4) begin
        n = 0;
      end else begin
        n = 1;
      end
      code = (b == 5) ? 5 : b + 1;
      for (int k = 0; k < n; k++) exp_q.push_back(code);
    end
    check_queue("random", exp_q);
    check("random_ovf", ovf, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
